rv_decode_stage: RTL and testbench

RV_DECODE_STAGE -- requirements
Module: rv_decode_stage

---
 rtl/rv_decode_stage.sv | 208 ++++++++++++++++++++
 tb/tb_rv_decode_stage.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_decode_stage.sv
// RV64 decode stage: decodes on the input side into a DEPTH-entry FIFO, head visible 1 cycle after push.
// Backpressure: in_ready drops when full, during flush, or in reset; a pop never frees space for a same-cycle push.
module rv_decode_stage #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int DEPTH          = 2,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               in_instr,
    input  logic [BUS_DATA_WIDTH-1:0] in_pc,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [BUS_DATA_WIDTH-1:0] out_pc,
    output logic [4:0]                out_rd,
    output logic [4:0]                out_rs1,
    output logic [4:0]                out_rs2,
    output logic [BUS_DATA_WIDTH-1:0] out_imm,
    output logic [2:0]                out_fmt,
    output logic [6:0]                out_opcode,
    output logic [2:0]                out_funct3,
    output logic [6:0]                out_funct7,
    output logic                      out_is_word,
    output logic                      out_rd_we,
    output logic                      out_illegal,
    output logic [CNT_WIDTH-1:0]      decoded_cnt,
    output logic [CNT_WIDTH-1:0]      illegal_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    typedef struct packed {
        logic [BUS_DATA_WIDTH-1:0] pc;
        logic [BUS_DATA_WIDTH-1:0] imm;
        logic [31:0]               instr;
        logic [2:0]                fmt;
        logic                      is_word;
        logic                      rd_we;
        logic                      illegal;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             last_q, last_d;
    entry_t             new_c, head_c;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic [CNT_WIDTH-1:0] dec_cnt_q, dec_cnt_d, ill_cnt_q, ill_cnt_d;
    logic               push, pop;

    logic [6:0]                opc_c, f7_c;
    logic [2:0]                f3_c, fmt_c;
    logic                      bad_c, rd_we_c;
    logic [BUS_DATA_WIDTH-1:0] imm_c;

    assign opc_c = in_instr[6:0];
    assign f3_c  = in_instr[14:12];
    assign f7_c  = in_instr[31:25];

    // Format classification plus the per-opcode funct3/funct7 legality rules.
    always_comb begin
        fmt_c = FMT_ILL;
        bad_c = 1'b0;
        case (opc_c)
            7'b0110111, 7'b0010111: fmt_c = FMT_U;
            7'b1101111:             fmt_c = FMT_J;
            7'b1100111: begin fmt_c = FMT_I; bad_c = (f3_c != 3'b000); end
            7'b0000011: begin fmt_c = FMT_I; bad_c = (f3_c == 3'b111); end
            7'b0010011, 7'b0011011: fmt_c = FMT_I;
            7'b0100011: begin fmt_c = FMT_S; bad_c = (f3_c > 3'b011); end
            7'b1100011: begin
                fmt_c = FMT_B;
                bad_c = (f3_c == 3'b010) || (f3_c == 3'b011);
            end
            7'b0110011, 7'b0111011: begin
                fmt_c = FMT_R;
                bad_c = !((f7_c == 7'b0000000) || (f7_c == 7'b0100000) || (f7_c == 7'b0000001));
            end
            default: bad_c = 1'b1;
        endcase
        if (in_instr[1:0] != 2'b11) begin
            bad_c = 1'b1;
        end
        if (bad_c) begin
            fmt_c = FMT_ILL;
        end
    end

    always_comb begin
        imm_c = '0;
        case (fmt_c)
            FMT_I: imm_c = {{(BUS_DATA_WIDTH-12){in_instr[31]}}, in_instr[31:20]};
            FMT_S: imm_c = {{(BUS_DATA_WIDTH-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            FMT_B: imm_c = {{(BUS_DATA_WIDTH-13){in_instr[31]}}, in_instr[31], in_instr[7],
                            in_instr[30:25], in_instr[11:8], 1'b0};
            FMT_U: imm_c = {{(BUS_DATA_WIDTH-32){in_instr[31]}}, in_instr[31:12], 12'b0};
            FMT_J: imm_c = {{(BUS_DATA_WIDTH-21){in_instr[31]}}, in_instr[31], in_instr[19:12],
                            in_instr[20], in_instr[30:21], 1'b0};
            default: imm_c = '0;
        endcase
    end

    assign rd_we_c = ((fmt_c == FMT_R) || (fmt_c == FMT_I) || (fmt_c == FMT_U) || (fmt_c == FMT_J))
                     && (in_instr[11:7] != 5'd0);

    always_comb begin
        new_c         = '0;
        new_c.pc      = in_pc;
        new_c.imm     = imm_c;
        new_c.instr   = in_instr;
        new_c.fmt     = fmt_c;
        new_c.is_word = (opc_c == 7'b0011011) || (opc_c == 7'b0111011);
        new_c.rd_we   = rd_we_c;
        new_c.illegal = bad_c;
    end

    assign in_ready  = reset && (occ_q < DEPTH_OCC) && !flush;
    assign out_valid = (occ_q != '0) && !flush;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // An empty queue shows the last popped entry; reset zeroes that register, so head reads 0 in reset.
    assign head_c = (occ_q != '0) ? mem_q[rd_ptr_q] : last_q;

    always_comb begin
        occ_d     = occ_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        last_d    = last_q;
        dec_cnt_d = dec_cnt_q;
        ill_cnt_d = ill_cnt_q;
        if (flush) begin
            occ_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d  = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
                last_d    = mem_q[rd_ptr_q];
                dec_cnt_d = dec_cnt_q + CNT_WIDTH'(1);
                if (mem_q[rd_ptr_q].illegal) begin
                    ill_cnt_d = ill_cnt_q + CNT_WIDTH'(1);
                end
            end
            case ({push, pop})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            last_q    <= '0;
            dec_cnt_q <= '0;
            ill_cnt_q <= '0;
        end else begin
            occ_q     <= occ_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            last_q    <= last_d;
            dec_cnt_q <= dec_cnt_d;
            ill_cnt_q <= ill_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= new_c;
        end
    end

    assign out_pc      = head_c.pc;
    assign out_imm     = head_c.imm;
    assign out_fmt     = head_c.fmt;
    assign out_is_word = head_c.is_word;
    assign out_rd_we   = head_c.rd_we;
    assign out_illegal = head_c.illegal;
    assign out_opcode  = head_c.instr[6:0];
    assign out_rd      = head_c.instr[11:7];
    assign out_funct3  = head_c.instr[14:12];
    assign out_rs1     = head_c.instr[19:15];
    assign out_rs2     = head_c.instr[24:20];
    assign out_funct7  = head_c.instr[31:25];
    assign decoded_cnt = dec_cnt_q;
    assign illegal_cnt = ill_cnt_q;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Randomized + directed bench for rv_decode_stage with a queue scoreboard and an arithmetic decode model.
module tb_rv_decode_stage;
    localparam int W  = 64;
    localparam int D  = 2;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, out_ready;
    logic          in_ready, out_valid;
    logic [31:0]   in_instr;
    logic [W-1:0]  in_pc, out_pc, out_imm;
    logic [4:0]    out_rd, out_rs1, out_rs2;
    logic [2:0]    out_fmt, out_funct3;
    logic [6:0]    out_opcode, out_funct7;
    logic          out_is_word, out_rd_we, out_illegal;
    logic [CW-1:0] decoded_cnt, illegal_cnt;

    rv_decode_stage #(.BUS_DATA_WIDTH(W), .DEPTH(D), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_opcode(out_opcode), .out_funct3(out_funct3),
        .out_funct7(out_funct7), .out_is_word(out_is_word), .out_rd_we(out_rd_we),
        .out_illegal(out_illegal), .decoded_cnt(decoded_cnt), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [2:0]  fmt;
        logic [63:0] imm;
        logic        rd_we;
        logic        ill;
        logic        word;
    } exp_t;

    exp_t          sb[$];
    int            tests = 0;
    int            fails = 0;
    logic [CW-1:0] exp_dec = '0;
    logic [CW-1:0] exp_ill = '0;
    logic [6:0]    ops [12] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h03, 7'h13,
                                7'h1b, 7'h23, 7'h63, 7'h33, 7'h3b, 7'h0f};
    logic [6:0]    f7s [3]  = '{7'h00, 7'h20, 7'h01};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode: format from the opcode table, immediate as a signed integer value.
    function automatic exp_t ref_decode(input logic [31:0] w, input logic [63:0] pc);
        exp_t   e;
        int     fmt;
        bit     bad;
        longint v;
        logic [6:0] opc = w[6:0];
        logic [2:0] f3  = w[14:12];
        logic [6:0] f7  = w[31:25];
        fmt = 7; bad = 0; v = 0;
        case (opc)
            7'h37, 7'h17: fmt = 4;
            7'h6f:        fmt = 5;
            7'h67:        begin fmt = 1; bad = (f3 != 0); end
            7'h03:        begin fmt = 1; bad = (f3 == 7); end
            7'h13, 7'h1b: fmt = 1;
            7'h23:        begin fmt = 2; bad = (f3 > 3); end
            7'h63:        begin fmt = 3; bad = (f3 == 2 || f3 == 3); end
            7'h33, 7'h3b: begin fmt = 0; bad = !(f7 == 0 || f7 == 32 || f7 == 1); end
            default:      bad = 1;
        endcase
        if (w[1:0] != 2'b11) bad = 1;
        if (bad) fmt = 7;
        case (fmt)
            1: begin v = longint'(w[31:20]); if (w[31]) v -= 64'sd4096; end
            2: begin v = longint'({w[31:25], w[11:7]}); if (w[31]) v -= 64'sd4096; end
            3: begin v = 2 * longint'({w[31], w[7], w[30:25], w[11:8]}); if (w[31]) v -= 64'sd8192; end
            4: begin v = 4096 * longint'(w[31:12]); if (w[31]) v -= 64'sh1_0000_0000; end
            5: begin v = 2 * longint'({w[31], w[19:12], w[20], w[30:21]}); if (w[31]) v -= 64'sd2097152; end
            default: v = 0;
        endcase
        e.instr = w;
        e.pc    = pc;
        e.fmt   = 3'(fmt);
        e.imm   = v;
        e.ill   = bad;
        e.word  = (opc == 7'h1b) || (opc == 7'h3b);
        e.rd_we = (fmt == 0 || fmt == 1 || fmt == 4 || fmt == 5) && (w[11:7] != 0);
        return e;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] w = $urandom;
        if ($urandom_range(0, 9) < 8) w[6:0] = ops[$urandom_range(0, 11)];
        if ($urandom_range(0, 1) == 1) w[31:25] = f7s[$urandom_range(0, 2)];
        return w;
    endfunction

    // Monitor: checks handshake signals and counters each cycle, pops and compares the head on each pop.
    always @(negedge clk) begin
        bit   do_push, do_pop;
        exp_t e;
        if (!reset) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_pc", out_pc, 0);
            chk("rst_out_imm", out_imm, 0);
            chk("rst_out_fmt", out_fmt, 0);
            chk("rst_decoded_cnt", decoded_cnt, 0);
            chk("rst_illegal_cnt", illegal_cnt, 0);
            sb.delete();
            exp_dec = '0;
            exp_ill = '0;
        end else begin
            do_push = in_valid && (sb.size() < D) && !flush;
            do_pop  = out_ready && (sb.size() > 0) && !flush;
            chk("in_ready", in_ready, (sb.size() < D) && !flush);
            chk("out_valid", out_valid, (sb.size() > 0) && !flush);
            chk("decoded_cnt", decoded_cnt, exp_dec);
            chk("illegal_cnt", illegal_cnt, exp_ill);
            if (do_pop) begin
                e = sb.pop_front();
                chk("head_pc", out_pc, e.pc);
                chk("head_rd", out_rd, e.instr[11:7]);
                chk("head_rs1", out_rs1, e.instr[19:15]);
                chk("head_rs2", out_rs2, e.instr[24:20]);
                chk("head_opcode", out_opcode, e.instr[6:0]);
                chk("head_funct3", out_funct3, e.instr[14:12]);
                chk("head_funct7", out_funct7, e.instr[31:25]);
                chk("head_fmt", out_fmt, e.fmt);
                chk("head_imm", out_imm, e.imm);
                chk("head_is_word", out_is_word, e.word);
                chk("head_rd_we", out_rd_we, e.rd_we);
                chk("head_illegal", out_illegal, e.ill);
                exp_dec = exp_dec + 1'b1;
                if (e.ill) exp_ill = exp_ill + 1'b1;
            end
            if (do_push) sb.push_back(ref_decode(in_instr, in_pc));
            if (flush) sb.delete();
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        bit ok = 0;
        in_valid = 1'b1;
        in_instr = w;
        in_pc    = {$urandom, $urandom};
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        sync();
        in_valid = 1'b0;
        chk("push_accepted", ok, 1);
    endtask

    task automatic pop_one();
        bit ok = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) begin ok = 1; break; end
        end
        sync();
        out_ready = 1'b0;
        chk("pop_taken", ok, 1);
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        #1;
        chk("init_out_valid", out_valid, 0);
        chk("init_in_ready", in_ready, 0);
        chk("init_out_imm", out_imm, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // all-zero word is illegal
        push(32'h0000_0000);
        @(negedge clk);
        chk("zero_illegal", out_illegal, 1);
        chk("zero_fmt", out_fmt, 7);
        chk("zero_imm", out_imm, 0);
        sync();
        pop_one();
        @(negedge clk);
        chk("zero_decoded_cnt", decoded_cnt, 1);
        chk("zero_illegal_cnt", illegal_cnt, 1);
        sync();

        // addi x1, x0, -1
        push(32'hFFF0_0093);
        @(negedge clk);
        chk("addi_fmt", out_fmt, 1);
        chk("addi_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi_rd", out_rd, 1);
        chk("addi_rd_we", out_rd_we, 1);
        sync();
        pop_one();

        // beq -4 followed by lui x5
        push(32'hFE00_0EE3);
        push(32'h1234_52B7);
        @(negedge clk);
        chk("beq_fmt", out_fmt, 3);
        chk("beq_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("beq_rd_we", out_rd_we, 0);
        sync();
        pop_one();
        @(negedge clk);
        chk("lui_fmt", out_fmt, 4);
        chk("lui_imm", out_imm, 64'h0000_0000_1234_5000);
        chk("lui_rd", out_rd, 5);
        sync();
        pop_one();

        // full queue blocks a push even with a same-cycle pop
        in_valid = 1'b1;
        in_instr = 32'h0010_0113;
        in_pc    = 64'h1000;
        sync();
        sync();
        out_ready = 1'b1;
        @(negedge clk);
        chk("full_in_ready", in_ready, 0);
        chk("full_out_valid", out_valid, 1);
        sync();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("after_pop_out_valid", out_valid, 1);
        chk("after_pop_in_ready", in_ready, 1);
        sync();

        // flush a full queue
        push(gen_instr());
        flush = 1'b1;
        @(negedge clk);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 0);
        sync();
        flush = 1'b0;
        @(negedge clk);
        chk("post_flush_out_valid", out_valid, 0);
        chk("post_flush_in_ready", in_ready, 1);
        chk("post_flush_cnt", decoded_cnt, exp_dec);
        sync();

        // drive decoded_cnt to all-ones, then wrap
        for (int i = 0; i < 20 && exp_dec != 4'hF; i++) begin
            push(gen_instr());
            pop_one();
        end
        @(negedge clk);
        chk("cnt_all_ones", decoded_cnt, 4'hF);
        sync();
        push(gen_instr());
        pop_one();
        @(negedge clk);
        chk("cnt_wrap", decoded_cnt, 0);
        sync();

        // reset with two entries queued
        push(gen_instr());
        push(gen_instr());
        #1 reset = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_out_pc", out_pc, 0);
        sync();
        sync();
        reset = 1'b1;

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            in_instr  = gen_instr();
            in_pc     = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            reset     = (i != 700);
            sync();
        end
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) sync();
        chk("drain_empty", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
